// File: rtl/oled_frame_scheduler.sv
// Sequences the SSD1306 init list, per-frame address window and framebuffer
// stream onto a single byte-wide SPI transmitter, with frame-tick coalescing.
module oled_frame_scheduler #(
    parameter int POR_DELAY   = 16,
    parameter int FRAME_BYTES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_dc,
    output logic       pix_req,
    output logic [9:0] pix_addr,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       init_done,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_skipped
);

    localparam int         POR_W     = $clog2(POR_DELAY + 1) + 1;
    localparam int         INIT_LEN  = 10;
    localparam int         ADDR_LEN  = 6;
    localparam logic [9:0] LAST_BYTE = 10'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        S_POR,
        S_INIT,
        S_IDLE,
        S_ADDR,
        S_FETCH,
        S_SEND
    } state_t;

    state_t           state_q;
    logic [POR_W-1:0] por_cnt_q;
    logic [3:0]       seq_idx_q;
    logic [3:0]       seq_idx_d;
    logic [9:0]       byte_cnt_q;
    logic [9:0]       byte_cnt_d;
    logic             pending_q;
    logic             tx_valid_q;
    logic [7:0]       tx_byte_q;
    logic             tx_dc_q;
    logic             pix_req_q;
    logic             init_done_q;
    logic             frame_done_q;
    logic             frame_skipped_q;
    logic             xfer;

    // Controller bring-up: charge pump on, horizontal addressing, contrast,
    // precharge, resume from RAM, display on.
    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h8D;
            4'd1:    b = 8'h14;
            4'd2:    b = 8'h20;
            4'd3:    b = 8'h00;
            4'd4:    b = 8'h81;
            4'd5:    b = 8'hCF;
            4'd6:    b = 8'hD9;
            4'd7:    b = 8'hF1;
            4'd8:    b = 8'hA4;
            default: b = 8'hAF;
        endcase
        return b;
    endfunction

    // Full-screen column window 0..127 and page window 0..7.
    function automatic logic [7:0] addr_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h21;
            4'd1:    b = 8'h00;
            4'd2:    b = 8'h7F;
            4'd3:    b = 8'h22;
            4'd4:    b = 8'h00;
            default: b = 8'h07;
        endcase
        return b;
    endfunction

    assign xfer       = tx_valid_q && tx_ready;
    assign seq_idx_d  = seq_idx_q + 4'd1;
    assign byte_cnt_d = byte_cnt_q + 10'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_POR;
            por_cnt_q       <= '0;
            seq_idx_q       <= '0;
            byte_cnt_q      <= '0;
            pending_q       <= 1'b0;
            tx_valid_q      <= 1'b0;
            tx_byte_q       <= 8'h00;
            tx_dc_q         <= 1'b0;
            pix_req_q       <= 1'b0;
            init_done_q     <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_skipped_q <= 1'b0;
        end else begin
            frame_done_q    <= 1'b0;
            frame_skipped_q <= 1'b0;

            // A second request while one is already queued is dropped.
            if (frame_tick && pending_q)
                frame_skipped_q <= 1'b1;
            if (frame_tick && state_q != S_IDLE)
                pending_q <= 1'b1;

            case (state_q)
                S_POR: begin
                    if (por_cnt_q == POR_W'(POR_DELAY)) begin
                        state_q    <= S_INIT;
                        seq_idx_q  <= '0;
                        tx_valid_q <= 1'b1;
                        tx_byte_q  <= init_byte(4'd0);
                        tx_dc_q    <= 1'b0;
                    end else begin
                        por_cnt_q <= por_cnt_q + 1'b1;
                    end
                end

                S_INIT: begin
                    if (xfer) begin
                        if (seq_idx_q == 4'(INIT_LEN - 1)) begin
                            tx_valid_q  <= 1'b0;
                            init_done_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            seq_idx_q <= seq_idx_d;
                            tx_byte_q <= init_byte(seq_idx_d);
                        end
                    end
                end

                S_IDLE: begin
                    if (pending_q || frame_tick) begin
                        pending_q  <= 1'b0;
                        state_q    <= S_ADDR;
                        seq_idx_q  <= '0;
                        tx_valid_q <= 1'b1;
                        tx_byte_q  <= addr_byte(4'd0);
                        tx_dc_q    <= 1'b0;
                    end
                end

                S_ADDR: begin
                    if (xfer) begin
                        if (seq_idx_q == 4'(ADDR_LEN - 1)) begin
                            tx_valid_q <= 1'b0;
                            byte_cnt_q <= '0;
                            pix_req_q  <= 1'b1;
                            state_q    <= S_FETCH;
                        end else begin
                            seq_idx_q <= seq_idx_d;
                            tx_byte_q <= addr_byte(seq_idx_d);
                        end
                    end
                end

                S_FETCH: begin
                    if (pix_valid) begin
                        pix_req_q  <= 1'b0;
                        tx_byte_q  <= pix_data;
                        tx_dc_q    <= 1'b1;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        // Explicit terminal compare keeps pix_addr from wrapping.
                        if (byte_cnt_q == LAST_BYTE) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_d;
                            pix_req_q  <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end

                default: state_q <= S_POR;
            endcase
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_byte       = tx_byte_q;
    assign tx_dc         = tx_dc_q;
    assign pix_req       = pix_req_q;
    assign pix_addr      = byte_cnt_q;
    assign init_done     = init_done_q;
    assign frame_done    = frame_done_q;
    assign frame_skipped = frame_skipped_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Self-checking bench for oled_frame_scheduler: randomized transmitter and
// renderer handshakes compared against an expected byte-stream model.
module tb_oled_frame_scheduler;

    localparam int POR = 4;
    localparam int FB  = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       tx_ready = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic       tx_valid, tx_dc, pix_req, init_done, busy, frame_done, frame_skipped;
    logic [7:0] tx_byte;
    logic [9:0] pix_addr;

    oled_frame_scheduler #(.POR_DELAY(POR), .FRAME_BYTES(FB)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_dc(tx_dc),
        .pix_req(pix_req), .pix_addr(pix_addr), .pix_data(pix_data), .pix_valid(pix_valid),
        .init_done(init_done), .busy(busy), .frame_done(frame_done),
        .frame_skipped(frame_skipped)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic dc; logic [7:0] b; } xfer_t;
    typedef struct { logic dc; logic [7:0] b; } exp_t;

    xfer_t obs_q[$];
    exp_t  exp_q[$];
    int    done_q[$];
    logic  done_busy_q[$];
    int    skip_q[$];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          init_done_cyc = -1;
    int unsigned stall_pct = 0;
    int unsigned wait_pct = 0;
    logic        scramble = 1'b0;
    logic        garbage = 1'b0;

    logic [7:0] init_list [10] = '{8'h8D, 8'h14, 8'h20, 8'h00, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hA4, 8'hAF};
    logic [7:0] addr_list [6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    // Renderer content: plain byte index, or a mix that exposes the page bits.
    function automatic logic [7:0] pix_fn(input logic [9:0] a, input logic scr);
        return scr ? (a[7:0] ^ {a[9:8], a[9:8], 4'h5}) : a[7:0];
    endfunction

    task automatic push_init();
        for (int i = 0; i < 10; i++) exp_q.push_back('{1'b0, init_list[i]});
    endtask

    task automatic push_frame(input logic scr);
        for (int i = 0; i < 6; i++) exp_q.push_back('{1'b0, addr_list[i]});
        for (int i = 0; i < FB; i++) exp_q.push_back('{1'b1, pix_fn(10'(i), scr)});
    endtask

    task automatic clear_logs();
        obs_q.delete(); exp_q.delete(); done_q.delete(); done_busy_q.delete(); skip_q.delete();
        init_done_cyc = -1;
    endtask

    task automatic pulse_tick(output int t);
        @(posedge clk); #1 frame_tick = 1'b1; t = cyc;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    // Handshake driver and transfer monitor; also enforces the hold rules.
    initial begin
        logic p_valid, p_xfer, p_dc, p_req, p_pv, p_rst, p_init;
        logic [7:0] p_byte;
        logic [9:0] p_addr;
        p_valid = 0; p_xfer = 0; p_dc = 0; p_req = 0; p_pv = 0; p_rst = 0; p_init = 0;
        p_byte = 0; p_addr = 0;
        forever begin
            @(posedge clk); cyc++;
            #1;
            tx_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            if (pix_req === 1'b1 && (wait_pct == 0 || $urandom_range(99) >= wait_pct)) begin
                pix_valid = 1'b1;
                pix_data  = pix_fn(pix_addr, scramble);
            end else begin
                pix_valid = (pix_req !== 1'b1 && garbage) ? 1'($urandom_range(1)) : 1'b0;
                pix_data  = 8'($urandom);
            end
            #1;
            if (p_rst && p_valid && !p_xfer) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_byte !== p_byte || tx_dc !== p_dc) begin
                    errors++;
                    $display("FAIL tx_hold cyc=%0d got v=%b b=%02h dc=%b required v=1 b=%02h dc=%b",
                             cyc, tx_valid, tx_byte, tx_dc, p_byte, p_dc);
                end
            end
            if (p_rst && p_req && !p_pv) begin
                checks++;
                if (pix_req !== 1'b1 || pix_addr !== p_addr) begin
                    errors++;
                    $display("FAIL pix_hold cyc=%0d got req=%b addr=%0d required req=1 addr=%0d",
                             cyc, pix_req, pix_addr, p_addr);
                end
            end
            if (rst_n && tx_valid === 1'b1 && tx_ready) obs_q.push_back('{cyc, tx_dc, tx_byte});
            if (frame_done === 1'b1) begin done_q.push_back(cyc); done_busy_q.push_back(busy); end
            if (frame_skipped === 1'b1) skip_q.push_back(cyc);
            if (init_done === 1'b1 && !p_init) init_done_cyc = cyc;
            p_valid = (tx_valid === 1'b1); p_xfer = (tx_valid === 1'b1) && tx_ready;
            p_dc = tx_dc; p_byte = tx_byte; p_req = (pix_req === 1'b1); p_pv = pix_valid;
            p_addr = pix_addr; p_rst = rst_n; p_init = (init_done === 1'b1);
        end
    end

    task automatic test_reset();
        int c0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if ({tx_valid, tx_byte, tx_dc, pix_req, pix_addr, init_done, frame_done, frame_skipped, busy}
            !== {1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got v=%b b=%02h dc=%b req=%b addr=%0d id=%b fd=%b fs=%b busy=%b required zeros busy=1",
                     tx_valid, tx_byte, tx_dc, pix_req, pix_addr, init_done, frame_done, frame_skipped, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1; c0 = cyc; clear_logs();
        for (int k = 1; k <= POR + 1; k++) begin
            @(posedge clk); #3;
            checks++;
            if (tx_valid !== 1'(k == POR + 1) || busy !== 1'b1) begin
                errors++;
                $display("FAIL por_wait cycle=%0d got v=%b busy=%b required v=%0d busy=1",
                         k, tx_valid, busy, (k == POR + 1));
            end
        end
        for (int k = 0; k < 40 && init_done !== 1'b1; k++) begin @(posedge clk); #3; end
        push_init();
        checks++;
        if (obs_q.size() != 10 || init_done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_end got n=%0d id=%b busy=%b v=%b required n=10 id=1 busy=0 v=0",
                     obs_q.size(), init_done, busy, tx_valid);
        end
        for (int i = 0; i < obs_q.size() && i < 10; i++) begin
            checks++;
            if (obs_q[i].b !== exp_q[i].b || obs_q[i].dc !== 1'b0 || obs_q[i].cyc != c0 + POR + 1 + i) begin
                errors++;
                $display("FAIL init_byte[%0d] got b=%02h dc=%b cyc=%0d required b=%02h dc=0 cyc=%0d",
                         i, obs_q[i].b, obs_q[i].dc, obs_q[i].cyc - c0, exp_q[i].b, POR + 1 + i);
            end
        end
        checks++;
        if (init_done_cyc != c0 + POR + 11) begin
            errors++;
            $display("FAIL init_done_time got %0d required %0d", init_done_cyc - c0, POR + 11);
        end
    endtask

    task automatic test_frame_zero_wait();
        int t, nerr;
        clear_logs(); stall_pct = 0; wait_pct = 0; scramble = 1'b0; garbage = 1'b0;
        pulse_tick(t);
        for (int k = 0; k < 2200 && done_q.size() < 1; k++) begin @(posedge clk); #3; end
        push_frame(1'b0);
        checks++;
        if (done_q.size() != 1 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL zw_count got done=%0d n=%0d required done=1 n=%0d", done_q.size(), obs_q.size(), exp_q.size());
        end
        nerr = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size() && nerr < 8; i++) begin
            checks++;
            if (obs_q[i].dc !== exp_q[i].dc || obs_q[i].b !== exp_q[i].b) begin
                errors++; nerr++;
                $display("FAIL zw_stream[%0d] got dc=%b b=%02h required dc=%b b=%02h",
                         i, obs_q[i].dc, obs_q[i].b, exp_q[i].dc, exp_q[i].b);
            end
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].cyc != t + 1) begin
                errors++; $display("FAIL zw_first_addr got %0d required %0d", obs_q[0].cyc - t, 1);
            end
        end
        if (done_q.size() > 0) begin
            checks++;
            if (done_q[0] != t + 6 + 2048 + 1 || done_busy_q[0] !== 1'b0) begin
                errors++;
                $display("FAIL zw_done_time got %0d busy=%b required %0d busy=0", done_q[0] - t, done_busy_q[0], 2055);
            end
        end
        repeat (5) @(posedge clk); #3;
        checks++;
        if (done_q.size() != 1 || skip_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zw_after got done=%0d skip=%0d busy=%b required done=1 skip=0 busy=0",
                     done_q.size(), skip_q.size(), busy);
        end
    endtask

    task automatic test_random_stalls();
        int t, nerr;
        clear_logs(); stall_pct = 35; wait_pct = 50; scramble = 1'b1; garbage = 1'b1;
        pulse_tick(t);
        for (int k = 0; k < 15000 && done_q.size() < 1; k++) begin @(posedge clk); #3; end
        push_frame(1'b1);
        checks++;
        if (done_q.size() != 1 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rs_count got done=%0d n=%0d required done=1 n=%0d", done_q.size(), obs_q.size(), exp_q.size());
        end
        nerr = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size() && nerr < 8; i++) begin
            checks++;
            if (obs_q[i].dc !== exp_q[i].dc || obs_q[i].b !== exp_q[i].b) begin
                errors++; nerr++;
                $display("FAIL rs_stream[%0d] got dc=%b b=%02h required dc=%b b=%02h",
                         i, obs_q[i].dc, obs_q[i].b, exp_q[i].dc, exp_q[i].b);
            end
        end
        stall_pct = 0; wait_pct = 0; scramble = 1'b0; garbage = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int t, t2, t3, nerr;
        clear_logs();
        pulse_tick(t);
        repeat (100) @(posedge clk);
        pulse_tick(t2);
        repeat (200) @(posedge clk);
        pulse_tick(t3);
        for (int k = 0; k < 5000 && done_q.size() < 2; k++) begin @(posedge clk); #3; end
        push_frame(1'b0); push_frame(1'b0);
        checks++;
        if (done_q.size() != 2 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got done=%0d n=%0d required done=2 n=%0d", done_q.size(), obs_q.size(), exp_q.size());
        end
        nerr = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size() && nerr < 8; i++) begin
            checks++;
            if (obs_q[i].dc !== exp_q[i].dc || obs_q[i].b !== exp_q[i].b) begin
                errors++; nerr++;
                $display("FAIL b2b_stream[%0d] got dc=%b b=%02h required dc=%b b=%02h",
                         i, obs_q[i].dc, obs_q[i].b, exp_q[i].dc, exp_q[i].b);
            end
        end
        checks++;
        if (skip_q.size() != 1 || (skip_q.size() == 1 && skip_q[0] != t3 + 1)) begin
            errors++;
            $display("FAIL b2b_skipped got n=%0d first=%0d required n=1 at %0d",
                     skip_q.size(), (skip_q.size() > 0) ? skip_q[0] - t : -1, t3 + 1 - t);
        end
        if (done_q.size() > 0 && obs_q.size() > 1030) begin
            checks++;
            if (obs_q[1030].cyc != done_q[0] + 1) begin
                errors++;
                $display("FAIL b2b_restart got %0d required %0d after frame_done", obs_q[1030].cyc - done_q[0], 1);
            end
        end
        repeat (20) @(posedge clk); #3;
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 2060 || done_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_settle got busy=%b n=%0d done=%0d required busy=0 n=2060 done=2",
                     busy, obs_q.size(), done_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int t;
        clear_logs();
        pulse_tick(t);
        for (int k = 0; k < 3000 && obs_q.size() < 6 + 500; k++) begin @(posedge clk); #3; end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        #2;
        checks++;
        if ({tx_valid, tx_byte, tx_dc, pix_req, pix_addr, init_done, frame_done, frame_skipped, busy}
            !== {1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_values got v=%b b=%02h dc=%b req=%b addr=%0d id=%b fd=%b fs=%b busy=%b required zeros busy=1",
                     tx_valid, tx_byte, tx_dc, pix_req, pix_addr, init_done, frame_done, frame_skipped, busy);
        end
        clear_logs();
        for (int k = 0; k < 60 && init_done !== 1'b1; k++) begin @(posedge clk); #3; end
        repeat (10) @(posedge clk); #3;
        push_init();
        checks++;
        if (obs_q.size() != 10 || busy !== 1'b0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_reinit got n=%0d busy=%b done=%0d required n=10 busy=0 done=0",
                     obs_q.size(), busy, done_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 10; i++) begin
            checks++;
            if (obs_q[i].b !== exp_q[i].b || obs_q[i].dc !== 1'b0) begin
                errors++;
                $display("FAIL midreset_init[%0d] got b=%02h dc=%b required b=%02h dc=0",
                         i, obs_q[i].b, obs_q[i].dc, exp_q[i].b);
            end
        end
    endtask

    task automatic test_tick_during_init();
        int t, nerr;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; clear_logs();
        repeat (POR + 2) @(posedge clk);
        pulse_tick(t);
        for (int k = 0; k < 2500 && done_q.size() < 1; k++) begin @(posedge clk); #3; end
        push_init(); push_frame(1'b0);
        checks++;
        if (done_q.size() != 1 || obs_q.size() != exp_q.size() || skip_q.size() != 0) begin
            errors++;
            $display("FAIL tdi_count got done=%0d n=%0d skip=%0d required done=1 n=%0d skip=0",
                     done_q.size(), obs_q.size(), skip_q.size(), exp_q.size());
        end
        nerr = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size() && nerr < 8; i++) begin
            checks++;
            if (obs_q[i].dc !== exp_q[i].dc || obs_q[i].b !== exp_q[i].b) begin
                errors++; nerr++;
                $display("FAIL tdi_stream[%0d] got dc=%b b=%02h required dc=%b b=%02h",
                         i, obs_q[i].dc, obs_q[i].b, exp_q[i].dc, exp_q[i].b);
            end
        end
        if (obs_q.size() > 10) begin
            checks++;
            if (obs_q[10].cyc != init_done_cyc + 1) begin
                errors++;
                $display("FAIL tdi_addr_start got %0d required %0d cycles after idle", obs_q[10].cyc - init_done_cyc, 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_zero_wait();
        test_random_stalls();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_during_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oled_frame_scheduler.md
# oled_frame_scheduler

Sequences the byte-level SPI transmitter feeding the 128x64 SSD1306 OLED. After power-on it issues the controller init command list once. On each frame strobe it issues the column/page address window, then fetches the 1024 framebuffer bytes one at a time from the tile renderer and streams them as display data. It is the only master of the transmitter, so command and pixel traffic never interleave.

## Interface
Parameters:
- POR_DELAY, 16: clk cycles spent in POR_WAIT after reset before the first command byte.
- FRAME_BYTES, 1024: data bytes per frame (128 columns x 8 pages).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- frame_tick  in  1  one-cycle strobe requesting a new frame.
- tx_valid  out  1  byte offered to the transmitter.
- tx_ready  in  1  transmitter accepts; a transfer occurs when tx_valid && tx_ready.
- tx_byte  out  8  byte to shift out, MSB first.
- tx_dc  out  1  0 = command, 1 = display data.
- pix_req  out  1  framebuffer byte request.
- pix_addr  out  10  requested byte index: page*128 + column.
- pix_data  in  8  renderer byte, sampled when pix_req && pix_valid.
- pix_valid  in  1  renderer response; may be high in the same cycle pix_req rises.
- init_done  out  1  sticky; high once the init list has fully transferred.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the last data byte of a frame transfers.
- frame_skipped  out  1  one-cycle pulse when a frame_tick is dropped.

## Operation
States and transitions:
- POR_WAIT: counts POR_DELAY cycles, then goes to INIT.
- INIT: sends 10 command bytes with tx_dc=0: 8D 14 20 00 81 CF D9 F1 A4 AF. After the 10th transfer, sets init_done and goes to IDLE.
- IDLE: if pending is set or frame_tick is high, clears pending and goes to ADDR; otherwise stays in IDLE.
- ADDR: sends 6 command bytes with tx_dc=0: 21 00 7F 22 00 07. Then clears the byte counter and goes to FETCH.
- FETCH: holds pix_req=1 with pix_addr equal to the byte counter. When pix_valid is seen, captures pix_data and goes to SEND.
- SEND: offers the captured byte with tx_dc=1. On transfer:
  - if counter == FRAME_BYTES-1, pulses frame_done and goes to IDLE;
  - otherwise increments the counter and goes to FETCH.

Frame-tick handling:
- A frame_tick outside IDLE sets a 1-deep pending flag.
- A frame_tick while pending is already set pulses frame_skipped; ticks coalesce.
- A frame_tick during POR_WAIT or INIT is treated the same way, so the first frame starts right after init.

Arithmetic and hold rules:
- Byte counter is 10 bits. Its terminal value is checked explicitly, and pix_addr never wraps past FRAME_BYTES-1.
- tx_byte and tx_dc are stable whenever tx_valid=1 and do not change until a transfer occurs.
- tx_valid never drops without a transfer.
- pix_addr is stable while pix_req=1.

Reset, including reset mid-frame:
- Registered outputs reset to: tx_valid=0, tx_byte=00, tx_dc=0, pix_req=0, pix_addr=0, init_done=0, frame_done=0, frame_skipped=0.
- pending=0, counter=0, state=POR_WAIT, so busy=1.
- The init list re-runs completely after every reset.

## Timing
- All outputs are registered except busy, which decodes state.
- Reset deasserted at cycle 0: first tx_valid=1 (byte 8D) at cycle POR_DELAY+1.
- Command bytes (INIT and ADDR) stream back-to-back: a transfer in cycle N puts the next byte on tx_byte in cycle N+1 with tx_valid still high.
  - Exception: the last INIT byte drops tx_valid in N+1.
  - The last ADDR byte also drops tx_valid in N+1; pix_req=1 for byte 0 in that same cycle.
- Pixel phase:
  - A data transfer in cycle N gives tx_valid=0 and pix_req=1 with the next address in N+1.
  - pix_valid in cycle M gives pix_req=0 and tx_valid=1 with that byte in M+1.
  - With zero-wait renderer and transmitter, this is 2 cycles per byte.
- frame_tick in IDLE at cycle T: tx_valid=1 with byte 21 at T+1.
- frame_done pulses in the cycle after the final data transfer; busy=0 in that same cycle.

## Test plan
- Reset, POR_DELAY=4, tx_ready tied 1 -> exactly 10 bytes 8D,14,20,00,81,CF,D9,F1,A4,AF with tx_dc=0 starting at cycle 5; then init_done=1, busy=0.
- frame_tick in IDLE, renderer returns pix_data=pix_addr[7:0] with zero wait -> bytes 21,00,7F,22,00,07 (dc=0), then 1024 bytes 00..FF repeating (dc=1); frame_done pulses once; total frame time 6+2048 cycles + 1.
- Random tx_ready stalls and random pix_valid delays -> tx_byte, tx_dc and pix_addr hold during stalls; byte sequence identical to the zero-wait case.
- Two frame_ticks during one frame -> one follow-on frame starts right after frame_done; frame_skipped pulses exactly once, on the second tick.
- rst_n low for 1 cycle at data byte 500 -> all outputs return to reset values next cycle; the init sequence is re-sent in full before any data byte.
- frame_tick during INIT -> the ADDR sequence begins the cycle after IDLE is entered; no frame_skipped pulse.
